// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among NUM_REQ producers.
// A local credit counter mirrors FIFO occupancy so no write ever targets a full FIFO.
module fifo_wr_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int DEPTH     = 16,
   parameter  int HEADROOM  = 1,
   parameter  int BURST_MAX = 4,
   localparam int LVL_W     = $clog2(DEPTH + 1),
   localparam int OWN_W     = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        fifo_wr_en,
   output logic [DATA_W-1:0]           fifo_din,
   input  logic                        fifo_rd_en,
   output logic [LVL_W-1:0]            level,
   output logic [OWN_W-1:0]            owner,
   output logic                        stall
);

   localparam int                CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [LVL_W-1:0]  LIMIT = LVL_W'(DEPTH - HEADROOM);
   localparam logic [CNT_W-1:0]  BMAX  = CNT_W'(BURST_MAX);

   typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

   state_t            state, state_next;
   logic [OWN_W-1:0]  owner_next, pick, idx;
   logic [CNT_W-1:0]  burst_cnt, burst_next;
   logic [LVL_W-1:0]  level_next;
   logic              found, credit, accept, rd_ok;

   assign credit     = (level < LIMIT);
   assign accept     = |(req & gnt);
   assign rd_ok      = fifo_rd_en && (level != '0);
   assign level_next = level + LVL_W'(accept) - LVL_W'(rd_ok);

   // Search starts just after the previous owner, so whoever just finished is seen last.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      pick  = owner;
      found = 1'b0;
      idx   = owner;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = OWN_W'((int'(owner) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (state == BURST) gnt[owner] = credit;
   end

   always_comb begin
      state_next = state;
      owner_next = owner;
      burst_next = burst_cnt;
      case (state)
         IDLE: begin
            if (found && credit) begin
               owner_next = pick;
               burst_next = '0;
               state_next = BURST;
            end
         end
         BURST: begin
            if (!credit) begin
               state_next = STALL;
            end else if (accept) begin
               burst_next = burst_cnt + 1'b1;
               if (burst_next == BMAX) state_next = IDLE;
            end else if (!req[owner]) begin
               state_next = IDLE;
            end
         end
         STALL: begin
            // Burst count survives the stall so the owner cannot exceed its quota.
            if (credit) state_next = req[owner] ? BURST : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= OWN_W'(NUM_REQ - 1);
         burst_cnt  <= '0;
         level      <= '0;
         fifo_wr_en <= 1'b0;
         fifo_din   <= '0;
         stall      <= 1'b0;
      end else begin
         owner      <= owner_next;
         burst_cnt  <= burst_next;
         level      <= level_next;
         fifo_wr_en <= accept;
         if (accept) fifo_din <= req_data[int'(owner)*DATA_W +: DATA_W];
         stall      <= (|req) && (level_next >= LIMIT);
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected writes are queued per test and a
// negedge monitor pops and compares {owner, fifo_din} on every FIFO write strobe.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic        fifo_rd_en = 1'b0;
   logic [3:0]  gnt;
   logic        fifo_wr_en;
   logic [7:0]  fifo_din;
   logic [4:0]  level;
   logic [1:0]  owner;
   logic        stall;

   int          checks = 0;
   int          errors = 0;
   int          wr_cnt = 0;
   logic [9:0]  sb[$];
   logic [9:0]  exp_w;

   int          cnt[4];
   int          nxt[4];
   logic [3:0]  pend_acc = '0;
   int          cyc = 0;
   int          first_acc, last_acc;
   int          wr_base;
   bit          found;

   fifo_wr_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .fifo_rd_en (fifo_rd_en),
      .level      (level),
      .owner      (owner),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] word(input int r, input int w);
      logic [1:0] o;
      o = 2'(r);
      return {o, 8'(r * 16 + w)};
   endfunction

   // Monitor: invariants every cycle, scoreboard pop on each write strobe.
   always @(negedge clk) begin
      if (rst_n) begin
         check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
         check("gnt_without_credit", 32'((|gnt) && (level >= 5'd15)), 0);
         if (fifo_wr_en) begin
            wr_cnt++;
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_w = sb.pop_front();
               check("wr_word", {22'b0, owner, fifo_din}, {22'b0, exp_w});
            end
         end
      end
   end

   // One cycle of producer behaviour: retire the accept seen at the last edge, present the next word.
   task automatic step();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (pend_acc[i]) begin
            cnt[i]--;
            nxt[i]++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
         end
      end
      for (int i = 0; i < 4; i++) begin
         req[i] = (cnt[i] > 0);
         req_data[i*8 +: 8] = 8'(i * 16 + nxt[i]);
      end
      pend_acc = req & gnt;
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n      = 1'b0;
      req        = '0;
      req_data   = '0;
      fifo_rd_en = 1'b0;
      pend_acc   = '0;
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0;
         nxt[i] = 0;
      end
      #1;
      check({tag, "_gnt"}, 32'(gnt), 0);
      check({tag, "_wr_en"}, 32'(fifo_wr_en), 0);
      check({tag, "_din"}, 32'(fifo_din), 0);
      check({tag, "_level"}, 32'(level), 0);
      check({tag, "_owner"}, 32'(owner), 3);
      check({tag, "_stall"}, 32'(stall), 0);
      check({tag, "_sb_drained"}, 32'(sb.size()), 0);
      sb.delete();
      @(posedge clk);
      #1;
      check({tag, "_edge_wr_en"}, 32'(fifo_wr_en), 0);
      check({tag, "_edge_level"}, 32'(level), 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0;
         nxt[i] = 0;
      end

      apply_reset("t1_por");

      // T2: lone requester 2, ten words -> bursts 4,4,2 with one idle cycle between bursts
      for (int w = 0; w < 10; w++) sb.push_back(word(2, w));
      wr_base   = wr_cnt;
      first_acc = -1;
      last_acc  = -1;
      cnt[2]    = 10;
      repeat (25) step();
      check("t2_level", 32'(level), 10);
      check("t2_accept_span", 32'(last_acc - first_acc), 11);
      check("t2_writes", 32'(wr_cnt - wr_base), 10);
      check("t2_owner", 32'(owner), 2);
      check("t2_stall", 32'(stall), 0);

      // T3: all four request; 4+4+4+3 words fill to the headroom limit, then stall
      apply_reset("t3_rst");
      for (int r = 0; r < 4; r++)
         for (int w = 0; w < ((r == 3) ? 3 : 4); w++) sb.push_back(word(r, w));
      for (int i = 0; i < 4; i++) cnt[i] = 8;
      repeat (30) step();
      check("t3_level", 32'(level), 15);
      check("t3_stall", 32'(stall), 1);
      check("t3_gnt", 32'(gnt), 0);
      check("t3_owner", 32'(owner), 3);
      check("t3_sb_drained", 32'(sb.size()), 0);

      // T4: one read frees one credit; owner 3 finishes its burst with one word
      sb.push_back(word(3, 3));
      fifo_rd_en = 1'b1;
      step();
      fifo_rd_en = 1'b0;
      check("t4_level_after_read", 32'(level), 14);
      repeat (6) step();
      check("t4_level", 32'(level), 15);
      check("t4_stall", 32'(stall), 1);
      check("t4_gnt", 32'(gnt), 0);
      check("t4_owner", 32'(owner), 3);
      check("t4_sb_drained", 32'(sb.size()), 0);

      // T5: accept and read on the same edge at level 7, then reads past empty
      apply_reset("t5_rst");
      for (int w = 0; w < 8; w++) sb.push_back(word(0, w));
      cnt[0] = 8;
      found  = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         step();
         if (level == 5'd7 && gnt[0]) found = 1'b1;
      end
      check("t5_reach_level7_with_gnt", 32'(found), 1);
      fifo_rd_en = 1'b1;
      step();
      fifo_rd_en = 1'b0;
      check("t5_level_accept_and_read", 32'(level), 7);
      fifo_rd_en = 1'b1;
      repeat (10) step();
      fifo_rd_en = 1'b0;
      step();
      check("t5_level_no_underflow", 32'(level), 0);
      check("t5_sb_drained", 32'(sb.size()), 0);

      // T6: owner 1 drops its request mid-burst; requester 2 is served next
      apply_reset("t6_rst");
      sb.push_back(word(1, 0));
      sb.push_back(word(1, 1));
      for (int w = 0; w < 3; w++) sb.push_back(word(2, w));
      cnt[1] = 2;
      cnt[2] = 3;
      repeat (15) step();
      check("t6_owner", 32'(owner), 2);
      check("t6_level", 32'(level), 5);
      check("t6_sb_drained", 32'(sb.size()), 0);

      // T1: reset mid-burst; words already accepted are written, nothing after
      apply_reset("t1_pre");
      for (int w = 0; w < 3; w++) sb.push_back(word(0, w));
      cnt[0]  = 8;
      wr_base = wr_cnt;
      found   = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         step();
         if (level == 5'd2) found = 1'b1;
      end
      check("t1_reach_level2", 32'(found), 1);
      apply_reset("t1_mid_burst");
      repeat (6) step();
      check("t1_writes_total", 32'(wr_cnt - wr_base), 3);
      check("t1_level_after", 32'(level), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
